// File: rtl/turn_judge.sv
// Memory-race turn judge: one player flips a card per turn. A correct flip advances
// that player's counter; a wrong flip stays visible for HOLD cycles, then the turn passes.
module turn_judge #(
  parameter int HOLD = 8
) (
  input  logic        B,
  input  logic        rst,
  input  logic [3:0]  N,
  input  logic [3:0]  card_sel,
  input  logic        card_go,
  input  logic [4:0]  p1_cnt,
  input  logic [4:0]  p2_cnt,
  input  logic [4:0]  p3_cnt,
  input  logic [4:0]  p4_cnt,
  output logic        p_da1,
  output logic        p_da2,
  output logic        p_da3,
  output logic        p_da4,
  output logic [1:0]  turn,
  output logic [11:0] card_up,
  output logic        miss
);

  typedef enum logic [1:0] {WAIT, CHECK, ADV, MISS} state_t;

  state_t      state, state_nx;
  logic [3:0]  sel;
  logic [7:0]  hold_cnt;
  logic [3:0]  p_da;
  logic [2:0]  n_eff;
  logic [4:0]  pos, tgt, img;
  logic        match, last;

  assign n_eff = (N >= 4'd2 && N <= 4'd4) ? N[2:0] : 3'd2;
  // Also catches turn >= N after N shrinks, sending the turn back to player 0.
  assign last  = ({1'b0, turn} + 3'd1) >= n_eff;

  always_comb begin
    pos = p1_cnt;
    case (turn)
      2'd1:    pos = p2_cnt;
      2'd2:    pos = p3_cnt;
      2'd3:    pos = p4_cnt;
      default: pos = p1_cnt;
    endcase
  end

  // Target tile wraps 23 -> 0; tile image is position mod 12.
  assign tgt   = (pos >= 5'd23) ? 5'd0 : pos + 5'd1;
  assign img   = (tgt >= 5'd12) ? tgt - 5'd12 : tgt;
  assign match = (img == {1'b0, sel}) && !card_up[sel];

  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (card_go && card_sel <= 4'd11) state_nx = CHECK;
      CHECK:   state_nx = match ? ADV : MISS;
      ADV:     state_nx = WAIT;
      MISS:    if (hold_cnt == 8'd0) state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  always_ff @(posedge B) begin
    if (rst) begin
      state    <= WAIT;
      turn     <= 2'd0;
      card_up  <= '0;
      p_da     <= '0;
      miss     <= 1'b0;
      hold_cnt <= 8'd0;
      sel      <= 4'd0;
    end else begin
      state <= state_nx;
      miss  <= (state_nx == MISS);
      p_da  <= '0;
      case (state)
        WAIT: if (state_nx == CHECK) sel <= card_sel;
        CHECK: begin
          card_up[sel] <= 1'b1;
          if (match) p_da[turn] <= 1'b1;
          else       hold_cnt   <= 8'(HOLD - 1);
        end
        MISS: begin
          if (hold_cnt == 8'd0) begin
            card_up <= '0;
            turn    <= last ? 2'd0 : turn + 2'd1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign p_da1 = p_da[0];
  assign p_da2 = p_da[1];
  assign p_da3 = p_da[2];
  assign p_da4 = p_da[3];

endmodule

// File: tb/tb_turn_judge.sv
// Bench for turn_judge: a vector table of flips run through a scoreboard queue,
// plus hand sequences for ignored requests, reset during MISS/CHECK, full board, and N changes.
module tb_turn_judge;
  localparam int HOLD = 8;

  logic        B = 1'b0, rst = 1'b1, card_go = 1'b0;
  logic [3:0]  N = 4'd2, card_sel = 4'd0;
  logic [4:0]  p1_cnt = 5'd0, p2_cnt = 5'd0, p3_cnt = 5'd0, p4_cnt = 5'd0;
  logic        p_da1, p_da2, p_da3, p_da4, miss;
  logic [1:0]  turn;
  logic [11:0] card_up;

  int n_chk = 0, n_pass = 0;

  always #5 B = ~B;

  turn_judge #(.HOLD(HOLD)) dut (
    .B(B), .rst(rst), .N(N), .card_sel(card_sel), .card_go(card_go),
    .p1_cnt(p1_cnt), .p2_cnt(p2_cnt), .p3_cnt(p3_cnt), .p4_cnt(p4_cnt),
    .p_da1(p_da1), .p_da2(p_da2), .p_da3(p_da3), .p_da4(p_da4),
    .turn(turn), .card_up(card_up), .miss(miss)
  );

  typedef struct {
    logic [3:0]  n;
    int          who;
    int          pos;
    logic [3:0]  sel;
    logic        match;
    logic [3:0]  pda;
    logic [11:0] up_now;
    logic [1:0]  turn_after;
  } vec_t;

  vec_t tbl[16];
  vec_t sb[$];

  function automatic vec_t mk(input logic [3:0] n, input int who, input int pos,
                              input logic [3:0] sel, input logic m,
                              input logic [11:0] up_now, input logic [1:0] turn_after);
    vec_t v;
    v.n = n; v.who = who; v.pos = pos; v.sel = sel; v.match = m;
    v.pda = m ? 4'(1 << who) : 4'd0;
    v.up_now = up_now; v.turn_after = turn_after;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // The active player sits at pos; the others sit 7 tiles away so a wrong player select misjudges.
  task automatic set_cnts(input int who, input int pos);
    int other;
    other  = (pos + 7) % 24;
    p1_cnt = 5'((who == 0) ? pos : other);
    p2_cnt = 5'((who == 1) ? pos : other);
    p3_cnt = 5'((who == 2) ? pos : other);
    p4_cnt = 5'((who == 3) ? pos : other);
  endtask

  task automatic do_reset();
    card_go = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge B);
    rst = 1'b0;
  endtask

  task automatic run_flip(input vec_t v);
    int   cyc, mlen;
    vec_t e;
    N = v.n;
    set_cnts(v.who, v.pos);
    @(negedge B);
    card_sel = v.sel; card_go = 1'b1;
    sb.push_back(v);
    @(negedge B);
    card_go = 1'b0;
    chk("check_quiet", {p_da4, p_da3, p_da2, p_da1, miss}, 0);
    cyc = 0;
    while (!(p_da1 | p_da2 | p_da3 | p_da4 | miss) && cyc < 20) begin
      @(negedge B); cyc++;
    end
    chk("latency", cyc, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("pda", {p_da4, p_da3, p_da2, p_da1}, e.pda);
    chk("miss_flag", miss, !e.match);
    chk("up_now", card_up, e.up_now);
    if (e.match) begin
      @(negedge B);
      chk("pda_single", {p_da4, p_da3, p_da2, p_da1}, 0);
      chk("up_after_match", card_up, e.up_now);
    end else begin
      mlen = 0;
      while (miss && mlen < 300) begin
        mlen++;
        @(negedge B);
      end
      chk("miss_len", mlen, HOLD);
      chk("up_after_miss", card_up, 0);
    end
    chk("turn_after", turn, e.turn_after);
  endtask

  initial begin
    int   mlen;
    logic saw;
    logic [11:0] acc;

    tbl[0]  = mk(2, 0, 0,  1,  1, 12'h002, 0);
    tbl[1]  = mk(2, 0, 1,  2,  1, 12'h006, 0);
    tbl[2]  = mk(2, 0, 1,  2,  0, 12'h006, 1);
    tbl[3]  = mk(2, 1, 23, 0,  1, 12'h001, 1);
    tbl[4]  = mk(2, 1, 23, 5,  0, 12'h021, 0);
    tbl[5]  = mk(3, 0, 5,  3,  0, 12'h008, 1);
    tbl[6]  = mk(3, 1, 10, 11, 1, 12'h800, 1);
    tbl[7]  = mk(3, 1, 11, 0,  1, 12'h801, 1);
    tbl[8]  = mk(3, 1, 11, 4,  0, 12'h811, 2);
    tbl[9]  = mk(4, 2, 14, 3,  1, 12'h008, 2);
    tbl[10] = mk(4, 2, 14, 7,  0, 12'h088, 3);
    tbl[11] = mk(4, 3, 2,  3,  1, 12'h008, 3);
    tbl[12] = mk(4, 3, 2,  9,  0, 12'h208, 0);
    tbl[13] = mk(7, 0, 0,  6,  0, 12'h040, 1);
    tbl[14] = mk(7, 1, 4,  5,  1, 12'h020, 1);
    tbl[15] = mk(7, 1, 4,  0,  0, 12'h021, 0);

    rst = 1'b1;
    repeat (2) @(negedge B);
    chk("rst_outs", {p_da4, p_da3, p_da2, p_da1, miss}, 0);
    chk("rst_turn", turn, 0);
    chk("rst_up", card_up, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_flip(tbl[i]);

    // Out-of-range card_sel is ignored.
    do_reset();
    N = 2; set_cnts(0, 0);
    @(negedge B); card_sel = 4'd13; card_go = 1'b1;
    @(negedge B); card_go = 1'b0;
    saw = 0;
    repeat (4) begin @(negedge B); if (p_da1 | p_da2 | p_da3 | p_da4 | miss) saw = 1; end
    chk("bad_sel_ignored", saw, 0);
    chk("bad_sel_up", card_up, 0);

    // card_go held through CHECK and ADV with a wrong card: only the first flip counts.
    @(negedge B); card_sel = 4'd1; card_go = 1'b1;
    @(negedge B); card_sel = 4'd5;
    @(negedge B); chk("go_in_check_pda", {p_da4, p_da3, p_da2, p_da1}, 4'b0001);
    @(negedge B); card_go = 1'b0;
    saw = 0;
    repeat (4) begin @(negedge B); if (p_da1 | p_da2 | p_da3 | p_da4 | miss) saw = 1; end
    chk("go_in_adv_ignored", saw, 0);
    chk("go_in_adv_up", card_up, 12'h002);

    // card_go with a matching card during MISS is ignored.
    do_reset();
    N = 2; set_cnts(0, 0);
    @(negedge B); card_sel = 4'd7; card_go = 1'b1;
    @(negedge B); card_go = 1'b0;
    @(negedge B); chk("miss_start", miss, 1);
    card_sel = 4'd1; card_go = 1'b1;
    saw = 0; mlen = 0;
    while (miss && mlen < 300) begin
      mlen++;
      @(negedge B);
      if (p_da1 | p_da2 | p_da3 | p_da4) saw = 1;
      if (mlen == 2) card_go = 1'b0;
    end
    chk("go_in_miss_len", mlen, HOLD);
    chk("go_in_miss_pda", saw, 0);
    chk("go_in_miss_turn", turn, 1);

    // Reset in the middle of MISS, then a flip in the first cycle after reset.
    do_reset();
    N = 2; set_cnts(0, 0);
    @(negedge B); card_sel = 4'd4; card_go = 1'b1;
    @(negedge B); card_go = 1'b0;
    repeat (4) @(negedge B);
    chk("pre_rst_miss", miss, 1);
    rst = 1'b1;
    @(negedge B);
    chk("rst_mid_miss", {p_da4, p_da3, p_da2, p_da1, miss}, 0);
    chk("rst_mid_up", card_up, 0);
    chk("rst_mid_turn", turn, 0);
    rst = 1'b0; card_sel = 4'd1; card_go = 1'b1;
    @(negedge B); card_go = 1'b0;
    @(negedge B); chk("post_rst_accept", {p_da4, p_da3, p_da2, p_da1}, 4'b0001);

    // Reset sampled in CHECK suppresses the advance pulse.
    do_reset();
    @(negedge B); card_sel = 4'd1; card_go = 1'b1;
    @(negedge B); card_go = 1'b0; rst = 1'b1;
    saw = 0;
    repeat (3) begin @(negedge B); if (p_da1 | p_da2 | p_da3 | p_da4) saw = 1; end
    chk("rst_in_check_nopda", saw, 0);
    rst = 1'b0;

    // Fill the whole board, then any further flip is a miss.
    do_reset();
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      acc[i] = 1'b1;
      run_flip(mk(2, 0, (i == 0) ? 23 : i - 1, 4'(i), 1, acc, 0));
    end
    run_flip(mk(2, 0, 23, 0, 0, 12'hfff, 1));

    // Walk to turn 3 with N=4, then shrink N to 2: the next turn update returns to 0.
    do_reset();
    run_flip(mk(4, 0, 0, 5, 0, 12'h020, 1));
    run_flip(mk(4, 1, 0, 5, 0, 12'h020, 2));
    run_flip(mk(4, 2, 0, 5, 0, 12'h020, 3));
    run_flip(mk(2, 3, 0, 5, 0, 12'h020, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/turn_judge.md
TURN_JUDGE -- requirements
Module: turn_judge

Interface
REQ-001 The block SHALL have parameter HOLD, default 8, giving the number of cycles a wrongly flipped card stays visible (legal range 1..255).
REQ-002 The block SHALL have port B, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-004 The block SHALL have port N, input, 4, the number of players; legal values are 2..4, and any other value is treated as 2.
REQ-005 The block SHALL have port card_sel, input, 4, the index (0..11) of the face-down card the player picks.
REQ-006 The block SHALL have port card_go, input, 1, a one-cycle pulse requesting a flip of card_sel.
REQ-007 The block SHALL have ports p1_cnt, p2_cnt, p3_cnt, p4_cnt, input, 5 each, giving the board positions (0..23) from the per-player counters.
REQ-008 The block SHALL have ports p_da1, p_da2, p_da3, p_da4, output, 1 each, each a one-cycle advance pulse to that player's counter.
REQ-009 The block SHALL have port turn, output, 2, the index of the current player (0..N-1).
REQ-010 The block SHALL have port card_up, output, 12, where bit i=1 means card i is face-up.
REQ-011 The block SHALL have port miss, output, 1, held high while a wrong card is displayed.

Function
REQ-012 The tile image at board position p SHALL be p mod 12.
REQ-013 The target tile for the current player SHALL be (pos+1) mod 24, where pos is p{turn+1}_cnt; position 23 targets tile 0.
REQ-014 A flip SHALL match when card_sel equals the image of the target tile and card_up[card_sel] is 0.
REQ-015 The block SHALL implement states WAIT, CHECK, ADV and MISS.
REQ-016 In WAIT, when card_go=1 and card_sel<=11, the block SHALL register card_sel and go to CHECK; otherwise it SHALL stay in WAIT.
REQ-017 In WAIT, a card_go with card_sel>11 SHALL be ignored, with no state change.
REQ-018 card_go SHALL be ignored in CHECK, ADV and MISS.
REQ-019 In CHECK on a match, the block SHALL set card_up[sel] and go to ADV.
REQ-020 In CHECK on a mismatch, the block SHALL set card_up[sel] (no change if already up), load the hold counter with HOLD-1, and go to MISS.
REQ-021 In ADV, exactly one of p_da1..p_da4, the one selected by turn, SHALL be high for that single cycle; the next state SHALL be WAIT, and turn SHALL be unchanged, so the same player continues.
REQ-022 Timing for an accepted flip: card_go sampled at edge t leads to CHECK in cycle t+1 and ADV (p_da high) in cycle t+2. The block SHALL be back in WAIT at t+3, with the counter already updated.
REQ-023 In MISS, the miss output SHALL be high and the hold counter SHALL decrement each cycle.
REQ-024 When the hold counter is 0 in MISS, at that edge the block SHALL clear card_up to all zeros, set turn to (turn+1) mod N, and go to WAIT; MISS SHALL last exactly HOLD cycles.
REQ-025 Turn wrap SHALL use the effective N: the last player (turn=N-1) passes to 0.
REQ-026 If N changes while turn >= N, the next turn update SHALL set turn to 0.
REQ-027 p_da1..p_da4 and miss SHALL be registered outputs, with no combinational path from any input.
REQ-028 When all 12 cards are up, any further card_go SHALL select an up card and therefore be a miss (per REQ-014).

Reset
REQ-029 When rst=1 at a rising edge of B, the block SHALL set state to WAIT, turn to 0, card_up to 0, p_da1..p_da4 to 0, miss to 0, and the hold counter to 0.
REQ-030 rst SHALL take priority over every other input, including reset asserted mid-ADV or mid-MISS, and no p_da pulse SHALL appear after rst is sampled.
REQ-031 In the first cycle after rst deasserts, the block SHALL accept card_go.

Verification
REQ-032 With N=2, p1_cnt=0, card_sel=1 and a card_go pulse: p_da1 SHALL be high in the 2nd cycle after the pulse and only then, card_up SHALL equal 12'h002, and turn SHALL stay 0.
REQ-033 With N=3, turn=0, p1_cnt=5, card_sel=3 (mismatch): miss SHALL be high for 8 cycles with card_up=12'h008; afterwards card_up SHALL be 0 and turn SHALL be 1.
REQ-034 With p2_cnt=23, turn=1, card_sel=0: the block SHALL treat it as a match (wrap to tile 0) and p_da2 SHALL pulse.
REQ-035 Re-flipping an already-up matching card SHALL produce a miss, with no p_da pulse.
REQ-036 With N=4 and turn=3, a miss SHALL give turn 0; with N=4'd7, the block SHALL behave as N=2.
REQ-037 A card_go during CHECK, ADV or MISS SHALL be ignored, and asserting rst during MISS SHALL return outputs to the reset values on the next edge.
